core_port_scheduler: RTL and testbench

//  Clocked scheduler for the node core's shared parity engine. The engine runs Hamming encode for

---
 rtl/core_port_scheduler.sv | 178 +++++++++++++++++
 tb/tb_core_port_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_port_scheduler.sv
// Shared parity-engine scheduler: arbitrates generator (encode) and router (decode) jobs,
// sequences start/done with timeout, counts completions. Optional macro: CORE_SCHED_WEIGHT_EN.
module core_port_scheduler #(
    parameter logic [1:0] CTRL_WORD = 2'd2,
    parameter int         GAP_CYC   = 2,
    parameter int         TIMEOUT   = 64,
    parameter int         CNT_W     = 16,
    parameter int         TX_WEIGHT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dg_req,
    input  logic             rx_req,
    output logic             dg_gnt,
    output logic             rx_gnt,
    output logic             eng_start,
    output logic             eng_sel,
    input  logic             eng_done,
    output logic [1:0]       ctrl_out,
    output logic             busy,
    output logic             timeout_o,
    output logic [CNT_W-1:0] tx_cnt,
    output logic [CNT_W-1:0] rx_cnt,
    output logic [1:0]       dbg_state
);

    // Handshake: dg_req/rx_req are levels held by the requester until its 1-cycle gnt;
    // eng_start is a 1-cycle pulse, eng_done a 1-cycle pulse that only counts while waiting.

    if (TIMEOUT < 2 || GAP_CYC < 0 || GAP_CYC > 15 || TX_WEIGHT < 1) begin : g_cfg_check
        $error("core_port_scheduler: illegal parameter set");
    end

    localparam int                WAIT_W    = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [3:0]        GAP_LAST  = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        gap_q, gap_d;
    logic [CNT_W-1:0]  tx_q, tx_d;
    logic [CNT_W-1:0]  rx_q, rx_d;
    logic              contended;
    logic              win_dec;
    logic              decide;

    assign contended = dg_req & rx_req;
    assign decide    = (state_q == S_IDLE) & contended;

`ifdef CORE_SCHED_WEIGHT_EN
    localparam int               WT_W     = $clog2(TX_WEIGHT + 1);
    localparam logic [WT_W-1:0]  WT_LIMIT = WT_W'(TX_WEIGHT);

    logic [WT_W-1:0] weight_q, weight_d;

    // Encode takes TX_WEIGHT contended wins, then decode takes one and the run restarts.
    assign win_dec = (weight_q == WT_LIMIT);

    always_comb begin
        weight_d = weight_q;
        if (decide) begin
            weight_d = win_dec ? '0 : weight_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weight_q <= '0;
        end else begin
            weight_q <= weight_d;
        end
    end
`else
    logic sel_last_q, sel_last_d;

    // Resets to decode so that the first contended decision favours encode.
    assign win_dec = ~sel_last_q;

    always_comb begin
        sel_last_d = sel_last_q;
        if (decide) begin
            sel_last_d = win_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_last_q <= 1'b1;
        end else begin
            sel_last_q <= sel_last_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        case (state_q)
            S_IDLE: begin
                if (dg_req | rx_req) begin
                    state_d = S_GRANT;
                    sel_d   = contended ? win_dec : rx_req;
                end
            end
            S_GRANT: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                // A done on the final wait cycle still completes the job.
                if (eng_done) begin
                    if (sel_q) begin
                        if (rx_q != '1) rx_d = rx_q + 1'b1;
                    end else begin
                        if (tx_q != '1) tx_d = tx_q + 1'b1;
                    end
                    state_d = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                    gap_d   = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            wait_q  <= '0;
            gap_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign eng_start = (state_q == S_GRANT);
    assign dg_gnt    = eng_start & ~sel_q;
    assign rx_gnt    = eng_start & sel_q;
    assign eng_sel   = sel_q;
    assign ctrl_out  = (((state_q == S_GRANT) || (state_q == S_WAIT)) && !sel_q) ? CTRL_WORD : 2'd0;
    // Flags the last wait cycle only when the engine has not answered in it.
    assign timeout_o = (state_q == S_WAIT) && (wait_q == WAIT_LAST) && !eng_done;
    assign tx_cnt    = tx_q;
    assign rx_cnt    = rx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_core_port_scheduler.sv
// Bench for core_port_scheduler: table of directed jobs, saturation/stray-done/drop/reset
// sequences, then random jobs checked against a transaction-level arbitration model.
module tb_core_port_scheduler;

    localparam int         GAP_CYC   = 2;
    localparam int         TIMEOUT   = 64;
    localparam int         CNT_W     = 4;
    localparam int         TX_WEIGHT = 3;
    localparam logic [1:0] CTRL_WORD = 2'd2;
    localparam int         CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             dg_req = 1'b0;
    logic             rx_req = 1'b0;
    logic             eng_done = 1'b0;
    logic             dg_gnt, rx_gnt, eng_start, eng_sel, busy, timeout_o;
    logic [1:0]       ctrl_out, dbg_state;
    logic [CNT_W-1:0] tx_cnt, rx_cnt;

    core_port_scheduler #(
        .CTRL_WORD (CTRL_WORD),
        .GAP_CYC   (GAP_CYC),
        .TIMEOUT   (TIMEOUT),
        .CNT_W     (CNT_W),
        .TX_WEIGHT (TX_WEIGHT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dg_req    (dg_req),
        .rx_req    (rx_req),
        .dg_gnt    (dg_gnt),
        .rx_gnt    (rx_gnt),
        .eng_start (eng_start),
        .eng_sel   (eng_sel),
        .eng_done  (eng_done),
        .ctrl_out  (ctrl_out),
        .busy      (busy),
        .timeout_o (timeout_o),
        .tx_cnt    (tx_cnt),
        .rx_cnt    (rx_cnt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: completion counts and arbitration history.
    int m_tx = 0;
    int m_rx = 0;
    int next_wait = 1;
`ifdef CORE_SCHED_WEIGHT_EN
    int m_w = 0;
`else
    logic m_last = 1'b1;
`endif

    typedef struct {
        logic dg;
        logic rx;
        int   lat;
        logic exp_sel;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_decide(input logic d, input logic r, output logic sel);
        if (d && r) begin
`ifdef CORE_SCHED_WEIGHT_EN
            if (m_w < TX_WEIGHT) begin
                sel = 1'b0;
                m_w++;
            end else begin
                sel = 1'b1;
                m_w = 0;
            end
`else
            sel    = ~m_last;
            m_last = sel;
`endif
        end else begin
            sel = r;
        end
    endtask

    task automatic add_vec(input logic d, input logic r, input int lat, input logic s);
        vec_t v;
        v.dg = d;
        v.rx = r;
        v.lat = lat;
        v.exp_sel = s;
        vecs.push_back(v);
    endtask

    // Requests must already be driven. Engine answers on WAIT cycle 'lat'; lat > TIMEOUT means never.
    task automatic do_job(input logic exp_sel, input int lat);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(dg_gnt || rx_gnt) && n < 300);
        chk("grant_cycle", n, next_wait);
        if (!(dg_gnt || rx_gnt)) return;
        chk("grant_start", eng_start, 1'b1);
        chk("grant_dg_gnt", dg_gnt, !exp_sel);
        chk("grant_rx_gnt", rx_gnt, exp_sel);
        chk("grant_sel", eng_sel, exp_sel);
        chk("grant_ctrl", ctrl_out, exp_sel ? 2'd0 : CTRL_WORD);
        if (exp_sel) rx_req = 1'b0;
        else dg_req = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            chk("wait_start", eng_start, 1'b0);
            chk("wait_gnt", dg_gnt | rx_gnt, 1'b0);
            chk("wait_sel", eng_sel, exp_sel);
            chk("wait_ctrl", ctrl_out, exp_sel ? 2'd0 : CTRL_WORD);
            chk("wait_busy", busy, 1'b1);
            if (k == lat) begin
                eng_done = 1'b1;
                #1;
                chk("timeout_vs_done", timeout_o, 1'b0);
                tick();
                eng_done = 1'b0;
                if (exp_sel) begin
                    if (m_rx < CNT_MAX) m_rx++;
                end else begin
                    if (m_tx < CNT_MAX) m_tx++;
                end
                chk("done_tx_cnt", tx_cnt, m_tx);
                chk("done_rx_cnt", rx_cnt, m_rx);
                chk("gap_busy", busy, 1'b1);
                chk("gap_ctrl", ctrl_out, 2'd0);
                next_wait = GAP_CYC + 1;
                return;
            end
            if (k == TIMEOUT) begin
                #1;
                chk("timeout_pulse", timeout_o, 1'b1);
            end else if (k == TIMEOUT - 1) begin
                chk("timeout_early", timeout_o, 1'b0);
            end
        end
        tick();
        chk("after_timeout_pulse", timeout_o, 1'b0);
        chk("after_timeout_idle", busy, 1'b0);
        chk("after_timeout_tx", tx_cnt, m_tx);
        chk("after_timeout_rx", rx_cnt, m_rx);
        next_wait = 1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dg_gnt"}, dg_gnt, 1'b0);
        chk({tag, "_rx_gnt"}, rx_gnt, 1'b0);
        chk({tag, "_start"}, eng_start, 1'b0);
        chk({tag, "_sel"}, eng_sel, 1'b0);
        chk({tag, "_ctrl"}, ctrl_out, 2'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_timeout"}, timeout_o, 1'b0);
        chk({tag, "_tx_cnt"}, tx_cnt, 0);
        chk({tag, "_rx_cnt"}, rx_cnt, 0);
    endtask

    initial begin
        logic       sel;
        logic [1:0] r;
        int         lat;

        // Directed job table: request pattern, engine latency, expected winner.
        add_vec(1'b1, 1'b0, 2, 1'b0);
        add_vec(1'b1, 1'b0, 1, 1'b0);
`ifdef CORE_SCHED_WEIGHT_EN
        add_vec(1'b1, 1'b1, 1, 1'b0);
        add_vec(1'b1, 1'b1, 3, 1'b0);
        add_vec(1'b1, 1'b1, 2, 1'b0);
        add_vec(1'b1, 1'b1, 1, 1'b1);
        add_vec(1'b1, 1'b1, 4, 1'b0);
        add_vec(1'b1, 1'b1, 2, 1'b0);
        add_vec(1'b1, 1'b1, 1, 1'b0);
        add_vec(1'b1, 1'b1, 2, 1'b1);
`else
        add_vec(1'b1, 1'b1, 1, 1'b0);
        add_vec(1'b1, 1'b1, 3, 1'b1);
        add_vec(1'b1, 1'b1, 2, 1'b0);
        add_vec(1'b1, 1'b1, 1, 1'b1);
        add_vec(1'b1, 1'b1, 4, 1'b0);
        add_vec(1'b1, 1'b1, 2, 1'b1);
`endif
        add_vec(1'b0, 1'b1, 100, 1'b1);
        add_vec(1'b0, 1'b1, TIMEOUT, 1'b1);
        add_vec(1'b1, 1'b0, 5, 1'b0);

        #1 rst_n = 1'b0;
        #2;
        chk_all_zero("reset");
        chk("reset_state", dbg_state, 2'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("idle_after_reset", busy, 1'b0);

        foreach (vecs[i]) begin
            dg_req = vecs[i].dg;
            rx_req = vecs[i].rx;
            model_decide(vecs[i].dg, vecs[i].rx, sel);
            do_job(vecs[i].exp_sel, vecs[i].lat);
        end
`ifdef CORE_SCHED_WEIGHT_EN
        chk("table_tx_total", tx_cnt, 9);
        chk("table_rx_total", rx_cnt, 3);
`else
        chk("table_tx_total", tx_cnt, 6);
        chk("table_rx_total", rx_cnt, 4);
`endif

        // Saturation of the encode counter.
        for (int j = 0; j < 17; j++) begin
            dg_req = 1'b1;
            rx_req = 1'b0;
            model_decide(1'b1, 1'b0, sel);
            do_job(1'b0, 1);
        end
        chk("tx_saturated", tx_cnt, CNT_MAX);

        // Stray done pulses in GAP and IDLE must not count.
        dg_req = 1'b0;
        rx_req = 1'b0;
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        tick();
        chk("stray_idle_busy", busy, 1'b0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("stray_busy", busy, 1'b0);
        chk("stray_tx", tx_cnt, m_tx);
        chk("stray_rx", rx_cnt, m_rx);
        next_wait = 1;

        // Request raised during GAP and dropped before IDLE is never granted.
        dg_req = 1'b1;
        model_decide(1'b1, 1'b0, sel);
        do_job(1'b0, 1);
        rx_req = 1'b1;
        tick();
        rx_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("dropped_no_gnt", dg_gnt | rx_gnt, 1'b0);
        end
        chk("dropped_idle", busy, 1'b0);
        next_wait = 1;

        // Random jobs: unserved requests stay pending, occasional engine that never answers.
        for (int j = 0; j < 40; j++) begin
            r = 2'($urandom_range(1, 3));
            dg_req = dg_req | r[0];
            rx_req = rx_req | r[1];
            model_decide(dg_req, rx_req, sel);
            lat = ($urandom_range(0, 9) == 0) ? TIMEOUT + 6 : int'($urandom_range(1, 6));
            do_job(sel, lat);
        end

        // Reset in the middle of WAIT, with a done pulse arriving while held in reset.
        dg_req = 1'b1;
        rx_req = 1'b0;
        repeat (next_wait) tick();
        chk("rst_job_gnt", dg_gnt, 1'b1);
        dg_req = 1'b0;
        tick();
        tick();
        chk("rst_job_waiting", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("midwait_reset");
        eng_done = 1'b1;
        tick();
        tick();
        eng_done = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");
        m_tx = 0;
        m_rx = 0;
`ifdef CORE_SCHED_WEIGHT_EN
        m_w = 0;
`else
        m_last = 1'b1;
`endif
        next_wait = 1;
        dg_req = 1'b1;
        rx_req = 1'b1;
        model_decide(1'b1, 1'b1, sel);
        chk("post_reset_first_contended", sel, 1'b0);
        do_job(sel, 3);
        dg_req = 1'b0;
        rx_req = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
